// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO read-side stream master.
//   DEF_WIDTH     : default data word width, shared with the fifo block
//   rd_state_e    : reader FSM state (IDLE / HOLD / STALL)
//   state_bits    : helper that turns a state into its debug encoding
// ----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_WIDTH = 32;

  // IDLE  : hold slot empty
  // HOLD  : hold slot full, waiting for a successor, burst end or timeout
  // STALL : hold slot full and the output word was refused by downstream
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    STALL = 2'd2
  } rd_state_e;

  function automatic logic [1:0] state_bits(input rd_state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// fifo_stream_reader
// Drains a first-word-fall-through FIFO into a valid/ready stream and frames
// the words into bursts. A burst closes after BURST_LEN words, or early when
// the FIFO stays empty for TIMEOUT consecutive cycles while a word is held.
//
// Ports
//   clk             : clock, all logic on its rising edge
//   rst             : asynchronous active-high reset
//   o_fifo_rd_en    : pop request to the FIFO (never asserted when empty)
//   i_fifo_rd_data  : FIFO head word
//   i_fifo_empty    : FIFO empty flag
//   o_vld           : output word valid
//   o_data          : output word
//   o_last          : last word of its burst, qualified by o_vld
//   i_rdy           : downstream ready
//   o_idle          : no word held internally
//   o_dbg_state     : current FSM state (rd_state_e encoding)
//
// Handshake: a word transfers on every rising edge where o_vld && i_rdy.
// Once o_vld is high, o_data/o_last stay constant until that transfer.
//
// Datapath: hold slot H (one word of look-ahead) feeds output slot O. A word
// waits in H until its successor is visible in the FIFO, so its last flag is
// known when it moves into O.
// ----------------------------------------------------------------------------
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             o_fifo_rd_en,
  input  logic [WIDTH-1:0] i_fifo_rd_data,
  input  logic             i_fifo_empty,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  input  logic             i_rdy,
  output logic             o_idle,
  output logic [1:0]       o_dbg_state
);

  localparam int BW = $clog2(BURST_LEN);
  localparam int IW = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  // Registers
  rd_state_e        r_state;
  logic [WIDTH-1:0] r_h_data;
  logic             r_o_vld;
  logic [WIDTH-1:0] r_o_data;
  logic             r_o_last;
  logic [BW-1:0]    r_beat_cnt;
  logic [IW-1:0]    r_idle_cnt;

  // Combinational
  rd_state_e        w_state_nxt;
  logic             w_h_vld;
  logic             w_h_vld_nxt;
  logic             w_o_vld_nxt;
  logic             w_o_free;
  logic             w_burst_end;
  logic             w_timed_out;
  logic             w_h_move;
  logic             w_last;
  logic             w_pop;

  // H is occupied in every state except IDLE.
  assign w_h_vld     = (r_state != IDLE);

  assign w_o_free    = !r_o_vld || i_rdy;
  assign w_burst_end = (r_beat_cnt == BEAT_MAX);
  assign w_timed_out = (r_idle_cnt == IDLE_MAX);

  // H's word may leave once its fate is known: it closes the burst by count,
  // a successor is visible, or the FIFO has been empty long enough.
  assign w_h_move = w_h_vld && w_o_free &&
                    (w_burst_end || !i_fifo_empty || w_timed_out);

  // Burst-length end wins over everything; otherwise a word is last only
  // when it leaves because of the timeout with nothing behind it.
  assign w_last = w_burst_end || (i_fifo_empty && w_timed_out);

  // Refill H whenever it is empty or being vacated this cycle. Gated by rst
  // so no word is consumed while the block is held in reset.
  assign w_pop = !rst && !i_fifo_empty && (!w_h_vld || w_h_move);

  // --------------------------------------------------------------------------
  // FSM next state and slot occupancy
  // --------------------------------------------------------------------------
  always_comb begin
    w_h_vld_nxt = w_h_vld;
    w_o_vld_nxt = r_o_vld;
    w_state_nxt = r_state;

    // A pop in the same cycle as a move replaces H rather than emptying it.
    if (w_pop) begin
      w_h_vld_nxt = 1'b1;
    end else if (w_h_move) begin
      w_h_vld_nxt = 1'b0;
    end

    if (w_h_move) begin
      w_o_vld_nxt = 1'b1;
    end else if (r_o_vld && i_rdy) begin
      w_o_vld_nxt = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_state_nxt = (r_o_vld && !i_rdy) ? STALL : HOLD;
        end
      end
      HOLD, STALL: begin
        if (!w_h_vld_nxt) begin
          w_state_nxt = IDLE;
        end else if (r_o_vld && !i_rdy) begin
          // O refused its word, so H could not move this cycle.
          w_state_nxt = STALL;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, slots and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_h_data   <= '0;
      r_o_vld    <= 1'b0;
      r_o_data   <= '0;
      r_o_last   <= 1'b0;
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_o_vld <= w_o_vld_nxt;

      if (w_pop) begin
        r_h_data <= i_fifo_rd_data;
      end

      if (w_h_move) begin
        r_o_data   <= r_h_data;
        r_o_last   <= w_last;
        r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
      end

      // Counts cycles a held word has seen an empty FIFO; saturates so it
      // keeps signalling timeout while downstream is stalled.
      if (!i_fifo_empty || w_h_move) begin
        r_idle_cnt <= '0;
      end else if (w_h_vld && !w_timed_out) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end

  assign o_fifo_rd_en = w_pop;
  assign o_vld        = r_o_vld;
  assign o_data       = r_o_data;
  assign o_last       = r_o_last;
  assign o_idle       = !w_h_vld && !r_o_vld;
  assign o_dbg_state  = state_bits(r_state);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_stream_reader
// Bench for fifo_stream_reader. A queue models the first-word-fall-through
// FIFO; every word written into it is also pushed to the expected queue with
// its hand-computed last flag and, where fixed, the cycle it must appear.
// A negedge monitor pops and compares whenever a word is transferred.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  localparam int W  = 32;
  localparam int BL = 16;
  localparam int TO = 8;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           at_cyc;   // -1: arrival cycle not checked
  } exp_t;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         o_fifo_rd_en;
  logic [W-1:0] i_fifo_rd_data = '0;
  logic         i_fifo_empty = 1'b1;
  logic         o_vld;
  logic [W-1:0] o_data;
  logic         o_last;
  logic         i_rdy = 1'b1;
  logic         o_idle;
  logic [1:0]   o_dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_stream_reader #(
    .WIDTH    (W),
    .BURST_LEN(BL),
    .TIMEOUT  (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .o_fifo_rd_en  (o_fifo_rd_en),
    .i_fifo_rd_data(i_fifo_rd_data),
    .i_fifo_empty  (i_fifo_empty),
    .o_vld         (o_vld),
    .o_data        (o_data),
    .o_last        (o_last),
    .i_rdy         (i_rdy),
    .o_idle        (o_idle),
    .o_dbg_state   (o_dbg_state)
  );

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  exp_t         exp_q[$];
  logic [W-1:0] fifo_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  bit           pop_s = 1'b0;
  bit           rdy_rand = 1'b0;
  bit           rdy_fixed = 1'b1;
  bit           quiet_chk = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;

  function automatic void chk(input string name, input logic [W-1:0] act,
                              input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  // One clock cycle: apply the pop the DUT requested at this edge, optionally
  // write a word, then present the new FIFO head and i_rdy.
  task automatic tick(input bit wr, input logic [W-1:0] wd, input bit lst,
                      input int lat);
    int k;
    @(posedge clk);
    #1;
    if (quiet_chk) begin
      chk("quiet_rd_en", W'(o_fifo_rd_en), '0);
      chk("quiet_idle", W'(o_idle), 1);
    end
    if (pop_s) begin
      chk("pop_had_word", W'(fifo_q.size() > 0), 1);
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    k = cyc;
    if (wr) begin
      fifo_q.push_back(wd);
      exp_q.push_back('{data: wd, last: lst, at_cyc: (lat >= 0) ? k + lat : -1});
    end
    i_rdy          = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    i_fifo_empty   = (fifo_q.size() == 0);
    i_fifo_rd_data = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !o_idle) && n < 300) begin
      tick(1'b0, '0, 1'b0, -1);
      n++;
    end
    n_tests++;
    if (n >= 300) begin
      n_fail++;
      $display("FAIL drain_%s: %0d words outstanding, o_idle=%0b, expected 0 and 1",
               tag, exp_q.size(), o_idle);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    pop_s = o_fifo_rd_en;
    if (o_fifo_rd_en) chk("rd_en_while_empty", W'(i_fifo_empty), '0);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_vld", W'(o_vld), 1);
        chk("stall_data", o_data, prev_data);
        chk("stall_last", W'(o_last), W'(prev_last));
      end
      if (o_vld && i_rdy) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", o_data);
        end else begin
          e = exp_q.pop_front();
          chk("data", o_data, e.data);
          chk("last", W'(o_last), W'(e.last));
          if (e.at_cyc >= 0) chk("arrival_cycle", W'(cyc), W'(e.at_cyc));
        end
      end
      prev_stall = o_vld && !i_rdy;
      prev_data  = o_data;
      prev_last  = o_last;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", W'(o_vld), '0);
    chk("rst_last", W'(o_last), '0);
    chk("rst_data", o_data, '0);
    chk("rst_idle", W'(o_idle), 1);
    chk("rst_rd_en", W'(o_fifo_rd_en), '0);
    chk("rst_state", W'(o_dbg_state), W'(state_bits(IDLE)));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 40 back-to-back words: last on 16, 32 and 40; every word two cycles
    // after its pop, word 40 only after the timeout.
    for (int i = 1; i <= 40; i++) begin
      tick(1'b1, 32'h1000_0000 + W'(i), (i % BL == 0) || (i == 40),
           (i == 40) ? TO + 2 : 2);
    end
    drain("b2b");

    // Single word closed by timeout
    tick(1'b1, 32'hDEAD_BEEF, 1'b1, TO + 2);
    drain("single");

    // 5 words, 7 empty cycles, 3 words: one 8-word burst
    for (int i = 1; i <= 5; i++) tick(1'b1, 32'h3000_0000 + W'(i), 1'b0, -1);
    repeat (7) tick(1'b0, '0, 1'b0, -1);
    for (int i = 6; i <= 8; i++) tick(1'b1, 32'h3000_0000 + W'(i), i == 8, -1);
    drain("gap");

    // 20 words with random backpressure
    rdy_rand = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b1, 32'h4000_0000 + W'(i), (i == 16) || (i == 20), -1);
    end
    drain("random_rdy");
    rdy_rand  = 1'b0;
    rdy_fixed = 1'b1;
    tick(1'b0, '0, 1'b0, -1);

    // Fill H and O against a stalled output, then reset
    rdy_fixed = 1'b0;
    tick(1'b1, 32'h5000_0001, 1'b0, -1);
    tick(1'b1, 32'h5000_0002, 1'b0, -1);
    tick(1'b1, 32'h5000_0003, 1'b0, -1);
    repeat (3) tick(1'b0, '0, 1'b0, -1);
    chk("stall_full_vld", W'(o_vld), 1);
    chk("stall_full_idle", W'(o_idle), '0);
    chk("stall_state", W'(o_dbg_state), W'(state_bits(STALL)));
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_vld", W'(o_vld), '0);
    chk("midrst_idle", W'(o_idle), 1);
    chk("midrst_rd_en", W'(o_fifo_rd_en), '0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_hold_rd_en", W'(o_fifo_rd_en), '0);
    fifo_q.delete();
    i_fifo_empty   = 1'b1;
    i_fifo_rd_data = '0;
    rdy_fixed      = 1'b1;
    i_rdy          = 1'b1;
    rst            = 1'b0;
    tick(1'b0, '0, 1'b0, -1);
    chk("postrst_vld", W'(o_vld), '0);
    chk("postrst_idle", W'(o_idle), 1);
    // Burst restarts from beat 0: the 16th word after reset is last
    for (int i = 1; i <= 16; i++) begin
      tick(1'b1, 32'h6000_0000 + W'(i), i == 16, 2);
    end
    drain("after_rst");

    // Empty FIFO for 100 cycles
    quiet_chk = 1'b1;
    repeat (100) tick(1'b0, '0, 1'b0, -1);
    quiet_chk = 1'b0;
    chk("quiet_state", W'(o_dbg_state), W'(state_bits(IDLE)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by 200000 ns");
    $fatal(1, "watchdog");
  end

endmodule
